// File: rtl/uart_imem_loader.sv
// UART boot loader: receives 8N1 bytes, assembles 16-bit words and writes them to
// instruction memory from address 0, then verifies an XOR checksum of the data bytes.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | counting to mid start bit to reject glitches
// RX_DATA  | sampling 8 data bits LSB first at mid-bit
// RX_STOP  | sampling the stop bit; emits byte_valid or frame_err
// L_IDLE   | waiting for the header byte
// L_COUNT  | next byte is the word count N (0 means 2^ADDR_W)
// L_HI     | next byte is a word's high byte
// L_LO     | next byte is the low byte; write cycle, then advance word_cnt
// L_CSUM   | next byte is the checksum
module uart_imem_loader #(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         ADDR_W       = 8,
   parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rxd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [15:0]       mem_datain,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_cnt
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int NW = ADDR_W + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [NW-1:0] WC_ONE   = NW'(1);
   localparam logic [NW-1:0] N_MAX    = {1'b1, {ADDR_W{1'b0}}};

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] L_IDLE  = 3'd0;
   localparam logic [2:0] L_COUNT = 3'd1;
   localparam logic [2:0] L_HI    = 3'd2;
   localparam logic [2:0] L_LO    = 3'd3;
   localparam logic [2:0] L_CSUM  = 3'd4;

   logic              rxd_s1_q, rxd_s2_q;
   logic [1:0]        rx_state_q, rx_state_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [7:0]        rx_shift_q, rx_shift_d;
   logic              byte_valid, frame_err;

   logic [2:0]        l_state_q, l_state_d;
   logic [NW-1:0]     n_q, n_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        acc_q, acc_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [15:0]       mem_datain_q, mem_datain_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [NW-1:0]     word_cnt_q, word_cnt_d;
   logic [NW-1:0]     cnt_inc;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rxd_s2_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = CNT_HALF;
            end
         end
         RX_START: begin
            if (rx_cnt_q == '0) begin
               if (rxd_s2_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = CNT_FULL;
                  rx_bit_d   = 3'd0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
               rx_cnt_d   = CNT_FULL;
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         default: begin
            // Byte is reported combinationally on the stop sample so the write lands one clock later.
            if (rx_cnt_q == '0) begin
               byte_valid = rxd_s2_q;
               frame_err  = !rxd_s2_q;
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
      endcase
   end

   always_comb begin
      l_state_d    = l_state_q;
      n_d          = n_q;
      hi_d         = hi_q;
      acc_d        = acc_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_datain_d = mem_datain_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_d        = err_q;
      word_cnt_d   = word_cnt_q;
      cnt_inc      = word_cnt_q + WC_ONE;
      case (l_state_q)
         L_IDLE: begin
            if (byte_valid && rx_shift_q == HDR_BYTE) begin
               done_d     = 1'b0;
               err_d      = 1'b0;
               word_cnt_d = '0;
               acc_d      = 8'h00;
               busy_d     = 1'b1;
               l_state_d  = L_COUNT;
            end
         end
         L_COUNT: begin
            if (byte_valid) begin
               n_d       = (rx_shift_q == 8'h00) ? N_MAX : NW'(rx_shift_q);
               l_state_d = L_HI;
            end
         end
         L_HI: begin
            if (byte_valid) begin
               hi_d      = rx_shift_q;
               acc_d     = acc_q ^ rx_shift_q;
               l_state_d = L_LO;
            end
         end
         L_LO: begin
            // mem_we_q marks the cycle after the write, when the word counter advances.
            if (mem_we_q) begin
               word_cnt_d = cnt_inc;
               l_state_d  = (cnt_inc == n_q) ? L_CSUM : L_HI;
            end else if (byte_valid) begin
               mem_we_d     = 1'b1;
               mem_addr_d   = word_cnt_q[ADDR_W-1:0];
               mem_datain_d = {hi_q, rx_shift_q};
               acc_d        = acc_q ^ rx_shift_q;
            end
         end
         L_CSUM: begin
            if (byte_valid) begin
               done_d    = (rx_shift_q == acc_q);
               err_d     = (rx_shift_q != acc_q);
               busy_d    = 1'b0;
               l_state_d = L_IDLE;
            end
         end
         default: l_state_d = L_IDLE;
      endcase
      if (frame_err && l_state_q != L_IDLE) begin
         err_d     = 1'b1;
         busy_d    = 1'b0;
         l_state_d = L_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_s1_q     <= 1'b1;
         rxd_s2_q     <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= 3'd0;
         rx_shift_q   <= 8'h00;
         l_state_q    <= L_IDLE;
         n_q          <= '0;
         hi_q         <= 8'h00;
         acc_q        <= 8'h00;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_datain_q <= 16'h0000;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         word_cnt_q   <= '0;
      end else begin
         rxd_s1_q     <= rxd;
         rxd_s2_q     <= rxd_s1_q;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         l_state_q    <= l_state_d;
         n_q          <= n_d;
         hi_q         <= hi_d;
         acc_q        <= acc_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_datain_q <= mem_datain_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_datain = mem_datain_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_cnt   = word_cnt_q;

endmodule
